// File: rtl/sysctrl_pkg.sv
// Shared definitions for the sysctrl host: FSM states, command codes and
// payload sizing used by the host and by anything that talks to it.
package sysctrl_pkg;

  localparam int unsigned SYSCTRL_PAYLOAD_DEPTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_GAP,
    ST_BYTE,
    ST_CAPT,
    ST_FIN
  } host_state_e;

  localparam logic [7:0] SYSCTRL_CMD_ID       = 8'h00;
  localparam logic [7:0] SYSCTRL_CMD_STATUS   = 8'h01;
  localparam logic [7:0] SYSCTRL_CMD_IRQ_MASK = 8'h02;
  localparam logic [7:0] SYSCTRL_CMD_IRQ_ACK  = 8'h03;
  localparam logic [7:0] SYSCTRL_CMD_RESET    = 8'h04;
  localparam logic [7:0] SYSCTRL_CMD_WR_REG   = 8'h05;
  localparam logic [7:0] SYSCTRL_CMD_RD_REG   = 8'h06;
  localparam logic [7:0] SYSCTRL_CMD_POWER    = 8'h07;
  localparam logic [7:0] SYSCTRL_CMD_NOP      = 8'h08;

  // A request can never move more bytes than the payload buffer holds.
  function automatic logic [4:0] clamp_len(input logic [4:0] len);
    return (len > 5'(SYSCTRL_PAYLOAD_DEPTH)) ? 5'(SYSCTRL_PAYLOAD_DEPTH) : len;
  endfunction

endpackage

// File: rtl/sysctrl_host_sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Shift the input through two flops to settle metastability.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/sysctrl_host.sv
// Host side of the sysctrl byte link: sends a command byte plus up to 16
// payload bytes with a fixed idle gap, captures one response byte per
// payload byte and reports each on a response pulse.
module sysctrl_host
  import sysctrl_pkg::*;
#(
  parameter int unsigned BYTE_GAP = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       pl_we,
  input  logic [3:0] pl_addr,
  input  logic [7:0] pl_data,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_cmd,
  input  logic [4:0] req_len,
  output logic       rsp_valid,
  output logic [3:0] rsp_index,
  output logic [7:0] rsp_data,
  output logic       done,
  output logic       irq,
  output logic       data_in_strobe,
  output logic       data_in_start,
  output logic [7:0] data_in,
  input  logic [7:0] data_out,
  input  logic       int_out_n
);

  localparam logic [7:0] GAP_LAST  = 8'(BYTE_GAP - 1);
  localparam logic [7:0] CAPT_LAST = 8'd1;

  host_state_e state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [4:0]  len_q, len_d;
  logic [7:0]  data_in_q, data_in_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [3:0]  rsp_index_q, rsp_index_d;
  logic [7:0]  rsp_data_q, rsp_data_d;
  logic        done_q, done_d;
  logic [7:0]  payload_q [SYSCTRL_PAYLOAD_DEPTH];

  logic accept;
  logic gap_last;
  logic capt_last;

  // done_q keeps req_ready low for the done cycle so a new request is only
  // accepted once the previous transaction has been fully reported.
  assign req_ready = (state_q == ST_IDLE) && !done_q;
  assign accept    = req_valid && req_ready;
  assign gap_last  = (cnt_q == GAP_LAST);
  assign capt_last = (cnt_q == CAPT_LAST);

  // State register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: sequence START, then GAP/BYTE/CAPT per byte, then FIN.
  // NOTE: state_d gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = ST_GAP;
      ST_GAP:   if (gap_last) state_d = (idx_q < len_q) ? ST_BYTE : ST_FIN;
      ST_BYTE:  state_d = ST_CAPT;
      ST_CAPT:  if (capt_last) state_d = ST_GAP;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Outputs and datapath next values derived from the current state.
  always_comb begin
    data_in_strobe = (state_q == ST_START) || (state_q == ST_BYTE);
    data_in_start  = (state_q == ST_START);

    // GAP and CAPT time themselves with the shared counter; it restarts on
    // every state change.
    cnt_d = ((state_d == state_q) && ((state_q == ST_GAP) || (state_q == ST_CAPT)))
            ? cnt_q + 8'd1 : 8'd0;

    idx_d       = idx_q;
    len_d       = len_q;
    data_in_d   = data_in_q;
    rsp_valid_d = 1'b0;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
    done_d      = (state_q == ST_FIN);

    // The command byte is latched straight into the data_in register, which
    // presents it during START.
    if (accept) begin
      len_d     = clamp_len(req_len);
      idx_d     = 5'd0;
      data_in_d = req_cmd;
    end

    // Preload the next payload byte so it is on data_in during BYTE.
    if ((state_q == ST_GAP) && (state_d == ST_BYTE)) begin
      data_in_d = payload_q[idx_q[3:0]];
    end

    if ((state_q == ST_CAPT) && capt_last) begin
      rsp_valid_d = 1'b1;
      rsp_index_d = idx_q[3:0];
      rsp_data_d  = data_out;
      idx_d       = idx_q + 5'd1;
    end
  end

  // Datapath and registered output flops.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= 8'd0;
      idx_q       <= 5'd0;
      len_q       <= 5'd0;
      data_in_q   <= 8'd0;
      rsp_valid_q <= 1'b0;
      rsp_index_q <= 4'd0;
      rsp_data_q  <= 8'd0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      data_in_q   <= data_in_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
      done_q      <= done_d;
    end
  end

  // Payload buffer: writable only while idle.
  // NOTE: the buffer has no reset so it maps onto plain storage; its contents
  // also have to survive a host reset.
  always_ff @(posedge clk) begin
    if (pl_we && (state_q == ST_IDLE)) begin
      payload_q[pl_addr] <= pl_data;
    end
  end

  assign data_in   = data_in_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_index = rsp_index_q;
  assign rsp_data  = rsp_data_q;
  assign done      = done_q;

  sync2 u_irq_sync (
    .clk   (clk),
    .rst_n (reset_n),
    .d_i   (!int_out_n),
    .q_o   (irq)
  );

endmodule

// File: tb/tb_sysctrl_host.sv
// Scoreboard bench for sysctrl_host with a small behavioural sysctrl device.
module tb_sysctrl_host;
  import sysctrl_pkg::*;

  localparam int GAP = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       pl_we;
  logic [3:0] pl_addr;
  logic [7:0] pl_data;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_cmd;
  logic [4:0] req_len;
  logic       rsp_valid;
  logic [3:0] rsp_index;
  logic [7:0] rsp_data;
  logic       done;
  logic       irq;
  logic       data_in_strobe;
  logic       data_in_start;
  logic [7:0] data_in;
  logic [7:0] data_out = 8'h00;
  logic       int_out_n;

  always #5 clk = ~clk;

  sysctrl_host #(.BYTE_GAP(GAP)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pl_we          (pl_we),
    .pl_addr        (pl_addr),
    .pl_data        (pl_data),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_cmd        (req_cmd),
    .req_len        (req_len),
    .rsp_valid      (rsp_valid),
    .rsp_index      (rsp_index),
    .rsp_data       (rsp_data),
    .done           (done),
    .irq            (irq),
    .data_in_strobe (data_in_strobe),
    .data_in_start  (data_in_start),
    .data_in        (data_in),
    .data_out       (data_out),
    .int_out_n      (int_out_n)
  );

  // ---------------- checking ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- sysctrl device model ----------------
  // ID returns a fixed signature, RESET echoes, everything else XORs 0xA5.
  function automatic logic [7:0] rsp_model(input logic [7:0] cmd, input int idx, input logic [7:0] b);
    if (cmd == SYSCTRL_CMD_ID) begin
      case (idx)
        0:       return 8'h5C;
        1:       return 8'h42;
        default: return 8'h00;
      endcase
    end else if (cmd == SYSCTRL_CMD_RESET) begin
      return b;
    end
    return b ^ 8'hA5;
  endfunction

  logic [7:0] m_cmd = 8'h00;
  logic [4:0] m_cnt = 5'd0;
  logic [7:0] m_first = 8'h00;
  logic       system_reset = 1'b1;

  always @(posedge clk) begin
    if (data_in_strobe) begin
      if (data_in_start) begin
        m_cmd <= data_in;
        m_cnt <= 5'd0;
      end else begin
        data_out <= rsp_model(m_cmd, int'(m_cnt), data_in);
        if (m_cmd == SYSCTRL_CMD_RESET) begin
          if (m_cnt == 5'd0) m_first <= data_in;
          else if ((m_cnt == 5'd1) && (m_first == 8'h52) && (data_in == 8'h00)) system_reset <= 1'b0;
        end
        m_cnt <= m_cnt + 5'd1;
      end
    end
  end

  // ---------------- scoreboard and monitor ----------------
  typedef struct packed {
    logic [3:0] idx;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] shadow [16];
  logic [7:0] exp_cmd;
  int         exp_len    = 0;
  int         cyc        = 0;
  int         last_strobe = 0;
  bit         prev_start = 1'b0;
  int         strobe_cnt = 0;
  int         done_cnt   = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset_n) begin
        if (data_in_strobe) begin
          if (data_in_start) begin
            check("start_cmd", data_in, exp_cmd);
            check("start_once", strobe_cnt, 0);
            prev_start = 1'b1;
          end else begin
            check("byte_spacing", cyc - last_strobe, prev_start ? GAP + 1 : GAP + 3);
            check("byte_in_len", strobe_cnt <= exp_len, 1);
            if (strobe_cnt >= 1 && strobe_cnt <= 16)
              check("byte_data", data_in, shadow[strobe_cnt-1]);
            prev_start = 1'b0;
          end
          last_strobe = cyc;
          strobe_cnt++;
        end
        if (rsp_valid) begin
          check("rsp_queued", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("rsp_index", rsp_index, e.idx);
            check("rsp_data", rsp_data, e.data);
          end
        end
        if (done) begin
          done_cnt++;
          check("done_strobes", strobe_cnt, exp_len + 1);
          check("done_sb_empty", sb.size(), 0);
          check("done_latency", cyc - last_strobe, (exp_len == 0) ? GAP + 2 : GAP + 4);
          check("done_ready_low", req_ready, 0);
        end
      end
    end
  end

  // ---------------- stimulus tasks ----------------
  task automatic pl_write(input logic [3:0] a, input logic [7:0] d);
    pl_we   = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(negedge clk);
    pl_we = 1'b0;
    shadow[a] = d;
  endtask

  task automatic run_req(input logic [7:0] cmd, input logic [4:0] len);
    int eff;
    int d0;
    int t;
    eff = (len > 5'd16) ? 16 : int'(len);
    t = 0;
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("ready_wait", req_ready, 1);
    exp_cmd    = cmd;
    exp_len    = eff;
    strobe_cnt = 0;
    for (int i = 0; i < eff; i++) sb.push_back('{idx: 4'(i), data: rsp_model(cmd, i, shadow[i])});
    d0 = done_cnt;
    req_cmd   = cmd;
    req_len   = len;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    check("busy_after_accept", req_ready, 0);
    t = 0;
    while (done_cnt == d0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check("done_once", done_cnt - d0, 1);
    check("data_in_hold", data_in, (eff == 0) ? cmd : shadow[eff-1]);
    @(negedge clk);
    check("ready_after_done", req_ready, 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int d0;
    reset_n   = 1'b0;
    pl_we     = 1'b0;
    pl_addr   = 4'd0;
    pl_data   = 8'd0;
    req_valid = 1'b0;
    req_cmd   = 8'd0;
    req_len   = 5'd0;
    int_out_n = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_req_ready", req_ready, 1);
    check("rst_strobe", data_in_strobe, 0);
    check("rst_start", data_in_start, 0);
    check("rst_data_in", data_in, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_index", rsp_index, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_done", done, 0);
    check("rst_irq", irq, 0);

    reset_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 16; i++) pl_write(4'(i), 8'(8'h30 + i));

    // ID command: signature bytes 0x5C, 0x42, 0x00.
    run_req(SYSCTRL_CMD_ID, 5'd3);

    // Reset command with "R",0x00 payload pulls system_reset low.
    pl_write(4'd0, 8'h52);
    pl_write(4'd1, 8'h00);
    check("sys_reset_before", system_reset, 1);
    run_req(SYSCTRL_CMD_RESET, 5'd2);
    check("sys_reset_after", system_reset, 0);

    // Zero-length request: command strobe only, then done.
    run_req(SYSCTRL_CMD_STATUS, 5'd0);

    // Interrupt synchronizer latency.
    int_out_n = 1'b0;
    @(negedge clk);
    check("irq_lat1", irq, 0);
    @(negedge clk);
    check("irq_lat2", irq, 1);
    int_out_n = 1'b1;
    @(negedge clk);
    check("irq_hold", irq, 1);
    @(negedge clk);
    check("irq_clear", irq, 0);

    // Payload writes and requests while busy are dropped.
    fork
      run_req(SYSCTRL_CMD_IRQ_ACK, 5'd4);
      begin
        repeat (3) @(negedge clk);
        pl_we     = 1'b1;
        pl_addr   = 4'd1;
        pl_data   = 8'hEE;
        req_valid = 1'b1;
        req_cmd   = SYSCTRL_CMD_POWER;
        req_len   = 5'd1;
        repeat (4) @(negedge clk);
        pl_we     = 1'b0;
        req_valid = 1'b0;
      end
    join
    run_req(SYSCTRL_CMD_RD_REG, 5'd2);

    // Full 16-byte payload, then an over-long request clamped to 16.
    for (int i = 0; i < 16; i++) pl_write(4'(i), 8'(i));
    run_req(SYSCTRL_CMD_WR_REG, 5'd16);
    run_req(SYSCTRL_CMD_IRQ_MASK, 5'd31);

    // Reset during the third payload byte of a len=8 request.
    exp_cmd    = SYSCTRL_CMD_WR_REG;
    exp_len    = 8;
    strobe_cnt = 0;
    for (int i = 0; i < 8; i++) sb.push_back('{idx: 4'(i), data: rsp_model(SYSCTRL_CMD_WR_REG, i, shadow[i])});
    req_cmd   = SYSCTRL_CMD_WR_REG;
    req_len   = 5'd8;
    req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    t = 0;
    while (strobe_cnt < 4 && t < 500) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("third_byte_reached", strobe_cnt, 4);
    check("third_byte_strobe", data_in_strobe, 1);
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("abort_strobe", data_in_strobe, 0);
    check("abort_start", data_in_start, 0);
    check("abort_ready", req_ready, 1);
    check("abort_done", done, 0);
    check("abort_rsp_valid", rsp_valid, 0);
    check("abort_data_in", data_in, 0);
    sb.delete();
    strobe_cnt = 0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_ready_after", req_ready, 1);

    // Payload survives the reset.
    run_req(SYSCTRL_CMD_RD_REG, 5'd8);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
